// File: rtl/tex_cache_responder_if.sv
// rtl/tex_cache_responder_if.sv - texture cache request/response bus bundle
interface tex_cache_responder_if #(
   parameter int NUM_REQS   = 4,
   parameter int WORD_SIZE  = 4,
   parameter int ADDR_WIDTH = 30,
   parameter int TAG_WIDTH  = 8
) ();
   logic [NUM_REQS-1:0]                req_valid;
   logic [NUM_REQS-1:0]                req_rw;
   logic [NUM_REQS*WORD_SIZE-1:0]      req_byteen;
   logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr;
   logic [NUM_REQS*WORD_SIZE*8-1:0]    req_data;
   logic [NUM_REQS*TAG_WIDTH-1:0]      req_tag;
   logic [NUM_REQS-1:0]                req_ready;
   logic [NUM_REQS-1:0]                rsp_valid;
   logic [NUM_REQS*WORD_SIZE*8-1:0]    rsp_data;
   logic [NUM_REQS*TAG_WIDTH-1:0]      rsp_tag;
   logic [NUM_REQS-1:0]                rsp_ready;

   modport master (
      output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_tag
   );

   modport slave (
      input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_tag
   );
endinterface

// File: rtl/tex_cache_responder.sv
// rtl/tex_cache_responder.sv - multi-port fixed-latency texture memory responder
// Optional feature macro: TEX_RESPONDER_STALL_EN (per-port LFSR backpressure on req_ready).
module tex_cache_responder #(
   parameter int NUM_REQS    = 4,
   parameter int WORD_SIZE   = 4,
   parameter int ADDR_WIDTH  = 30,
   parameter int TAG_WIDTH   = 8,
   parameter int MEM_WORDS   = 1024,
   parameter int LATENCY     = 4,
   parameter int QUEUE_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   tex_cache_responder_if.slave  bus
);
   localparam int DW    = WORD_SIZE * 8;
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DW-1:0]       mem_q [MEM_WORDS];
   logic [NUM_REQS-1:0] ready_w;
   logic [NUM_REQS-1:0] wr_fire;

   assign wr_fire       = bus.req_valid & ready_w & bus.req_rw;
   assign bus.req_ready = ready_w;

   // Byte-granular array writes; later loop iterations (higher ports) win on collisions
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_REQS; p++) begin
         for (int b = 0; b < WORD_SIZE; b++) begin
            if (wr_fire[p] && bus.req_byteen[p*WORD_SIZE + b]) begin
               mem_q[bus.req_addr[p*ADDR_WIDTH +: IDX_W]][b*8 +: 8] <= bus.req_data[(p*WORD_SIZE + b)*8 +: 8];
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_REQS; p++) begin : g_port
      logic [IDX_W-1:0]     idx;
      logic                 rd_fire;
      logic                 rsp_fire;
      logic                 push;
      logic                 stall_ok;
      logic                 rdy_q;
      logic [LATENCY-1:0]   pv_q;
      logic [DW-1:0]        pd_q [LATENCY];
      logic [TAG_WIDTH-1:0] pt_q [LATENCY];
      logic [DW-1:0]        fd_q [QUEUE_DEPTH];
      logic [TAG_WIDTH-1:0] ft_q [QUEUE_DEPTH];
      logic [PTR_W-1:0]     wp_q, rp_q;
      logic [CNT_W-1:0]     cnt_q;
      logic [CNT_W-1:0]     out_q, out_d;

      assign idx      = bus.req_addr[p*ADDR_WIDTH +: IDX_W];
      assign rd_fire  = bus.req_valid[p] & rdy_q & ~bus.req_rw[p];
      assign rsp_fire = (cnt_q != '0) & bus.rsp_ready[p];
      assign push     = pv_q[LATENCY-1];
      assign out_d    = out_q + CNT_W'(rd_fire) - CNT_W'(rsp_fire);
      assign ready_w[p] = rdy_q;

      assign bus.rsp_valid[p]                      = (cnt_q != '0);
      assign bus.rsp_data[p*DW +: DW]              = (cnt_q != '0) ? fd_q[rp_q] : '0;
      assign bus.rsp_tag[p*TAG_WIDTH +: TAG_WIDTH] = (cnt_q != '0) ? ft_q[rp_q] : '0;

`ifdef TEX_RESPONDER_STALL_EN
      logic [15:0] lfsr_q, lfsr_d;
      assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      // ready is registered, so it is masked by the LFSR value of the cycle it is visible in
      assign stall_ok = (lfsr_d[1:0] != 2'b00);

      // Free-running backpressure pattern, restarted from the per-port seed on reset
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) lfsr_q <= 16'hACE1 + 16'(p);
         else        lfsr_q <= lfsr_d;
      end
`else
      assign stall_ok = 1'b1;
`endif

      // Valid bits of the read pipeline; cleared on reset so in-flight reads vanish
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) pv_q <= '0;
         else        pv_q <= (pv_q << 1) | LATENCY'(rd_fire);
      end

      // Payload of the read pipeline; stage 0 samples the array before same-edge writes land
      always_ff @(posedge clk) begin
         pd_q[0] <= mem_q[idx];
         pt_q[0] <= bus.req_tag[p*TAG_WIDTH +: TAG_WIDTH];
         for (int s = 1; s < LATENCY; s++) begin
            pd_q[s] <= pd_q[s-1];
            pt_q[s] <= pt_q[s-1];
         end
      end

      // Response queue storage
      always_ff @(posedge clk) begin
         if (push) begin
            fd_q[wp_q] <= pd_q[LATENCY-1];
            ft_q[wp_q] <= pt_q[LATENCY-1];
         end
      end

      // Response queue pointers and occupancy
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push)     wp_q <= wp_q + 1'b1;
            if (rsp_fire) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(rsp_fire);
         end
      end

      // Credit counter and registered ready derived from next-cycle credits
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            out_q <= '0;
            rdy_q <= 1'b0;
         end else begin
            out_q <= out_d;
            rdy_q <= (out_d < CNT_W'(QUEUE_DEPTH)) & stall_ok;
         end
      end

      // Credits must keep the response queue from ever overflowing
      always_ff @(posedge clk) begin
         if (reset) begin
            assert (!(push && cnt_q == CNT_W'(QUEUE_DEPTH)))
               else $error("tex_cache_responder: response queue overflow on port %0d", p);
         end
      end
   end
endmodule

// File: tb/tb_tex_cache_responder.sv
// tb/tb_tex_cache_responder.sv - scoreboard bench for tex_cache_responder
module tb_tex_cache_responder;
   localparam int NR = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   err_cnt = 0;
   int   chk_cnt = 0;

   exp_t        sb [NR][$];
   logic [31:0] mdl [1024];
   exp_t        e;
   logic [29:0] a;
   logic [9:0]  ix;

   tex_cache_responder_if bus ();

   tex_cache_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard: compare responses, then queue reads (pre-write view), then apply writes
   always @(negedge clk) begin
      if (!reset) begin
         for (int p = 0; p < NR; p++) sb[p].delete();
      end else begin
         for (int p = 0; p < NR; p++) begin
            if (bus.rsp_valid[p] && bus.rsp_ready[p]) begin
               if (sb[p].size() == 0) begin
                  check("unexpected_rsp", 1, 0);
               end else begin
                  e = sb[p].pop_front();
                  check("rsp_data", bus.rsp_data[p*32 +: 32], e.data);
                  check("rsp_tag", bus.rsp_tag[p*8 +: 8], e.tag);
               end
            end
         end
         for (int p = 0; p < NR; p++) begin
            if (bus.req_valid[p] && bus.req_ready[p] && !bus.req_rw[p]) begin
               a = bus.req_addr[p*30 +: 30];
               ix = a[9:0];
               sb[p].push_back({mdl[ix], bus.req_tag[p*8 +: 8]});
            end
         end
         for (int p = 0; p < NR; p++) begin
            if (bus.req_valid[p] && bus.req_ready[p] && bus.req_rw[p]) begin
               a = bus.req_addr[p*30 +: 30];
               ix = a[9:0];
               for (int b = 0; b < 4; b++)
                  if (bus.req_byteen[p*4 + b]) mdl[ix][b*8 +: 8] = bus.req_data[p*32 + b*8 +: 8];
            end
         end
      end
   end

   task automatic set_req(input int p, input bit rw, input logic [3:0] be, input logic [29:0] addr,
                          input logic [31:0] data, input logic [7:0] tag);
      bus.req_rw[p]             = rw;
      bus.req_byteen[p*4 +: 4]  = be;
      bus.req_addr[p*30 +: 30]  = addr;
      bus.req_data[p*32 +: 32]  = data;
      bus.req_tag[p*8 +: 8]     = tag;
      bus.req_valid[p]          = 1'b1;
   endtask

   task automatic go();
      int n = 0;
      @(negedge clk);
      while (((bus.req_valid & ~bus.req_ready) != '0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("req_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("drain_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_fire;
      int k;
      bus.req_valid  = '0;
      bus.req_rw     = '0;
      bus.req_byteen = '0;
      bus.req_addr   = '0;
      bus.req_data   = '0;
      bus.req_tag    = '0;
      bus.rsp_ready  = 4'hF;
      reset          = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 4'h0);
      check("rst_rsp_valid", bus.rsp_valid, 4'h0);
      check("rst_rsp_data", bus.rsp_data, 128'h0);
      check("rst_rsp_tag", bus.rsp_tag, 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("ready_before_edge", bus.req_ready, 4'h0);
      @(negedge clk);
      check("ready_after_edge", bus.req_ready, 4'hF);

      // Known contents for every address read later
      set_req(2, 1'b1, 4'hF, 30'h10, 32'h0, 8'h0); go();
      set_req(2, 1'b1, 4'hF, 30'h20, 32'h0, 8'h0); go();
      set_req(2, 1'b1, 4'hF, 30'h30, 32'h0, 8'h0); go();
      for (int i = 0; i < 9; i++) begin
         set_req(2, 1'b1, 4'hF, 30'h100 + 30'(i), 32'hC0DE0000 + 32'(i), 8'h0);
         go();
      end

      // Write then read with latency measurement
      set_req(0, 1'b1, 4'hF, 30'h10, 32'hDEADBEEF, 8'h0); go();
      set_req(0, 1'b0, 4'h0, 30'h10, 32'h0, 8'h5A); go();
      t_fire = cyc;
      k = 0;
      while (!bus.rsp_valid[0] && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("rd_latency", cyc - t_fire, 4);
      drain();

      // Same-cycle write and read: read sees the old value
      set_req(0, 1'b1, 4'hF, 30'h20, 32'h11111111, 8'h0);
      set_req(1, 1'b0, 4'h0, 30'h20, 32'h0, 8'h21);
      go();
      set_req(1, 1'b0, 4'h0, 30'h20, 32'h0, 8'h22); go();
      drain();

      // Credit exhaustion on port 1
      @(posedge clk);
      #1 bus.rsp_ready[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_req(1, 1'b0, 4'h0, 30'h100 + 30'(i), 32'h0, 8'(i));
         go();
      end
      set_req(1, 1'b0, 4'h0, 30'h108, 32'h0, 8'h8);
      @(negedge clk);
      check("credit_block", bus.req_ready[1], 1'b0);
      repeat (6) @(negedge clk);
      check("credit_block_hold", bus.req_ready[1], 1'b0);
      check("queue_full_valid", bus.rsp_valid[1], 1'b1);
      @(posedge clk);
      #1 bus.rsp_ready[1] = 1'b1;
      @(negedge clk);
      check("ready_before_pop", bus.req_ready[1], 1'b0);
      @(negedge clk);
      check("ready_after_pop", bus.req_ready[1], 1'b1);
      @(posedge clk);
      #1 bus.req_valid = '0;
      drain();

      // Multi-port collision and partial byte write
      set_req(0, 1'b1, 4'hF, 30'h30, 32'hAAAAAAAA, 8'h0);
      set_req(3, 1'b1, 4'hF, 30'h30, 32'h55555555, 8'h0);
      go();
      set_req(3, 1'b0, 4'h0, 30'h30, 32'h0, 8'h40); go();
      set_req(1, 1'b1, 4'h1, 30'h30, 32'h000000FF, 8'h0); go();
      set_req(1, 1'b0, 4'h0, 30'h30, 32'h0, 8'h41); go();
      drain();

      // Reset with reads in flight
      set_req(2, 1'b0, 4'h0, 30'h100, 32'h0, 8'h70); go();
      set_req(2, 1'b0, 4'h0, 30'h101, 32'h0, 8'h71); go();
      set_req(2, 1'b0, 4'h0, 30'h102, 32'h0, 8'h72); go();
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_ready", bus.req_ready, 4'h0);
      check("mid_rst_valid", bus.rsp_valid, 4'h0);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("no_rsp_after_reset", bus.rsp_valid, 4'h0);
      end
      set_req(2, 1'b0, 4'h0, 30'h10, 32'h0, 8'h73); go();
      drain();

      // Address aliasing above the index bits
      set_req(2, 1'b0, 4'h0, 30'(1024 + 16), 32'h0, 8'h60); go();
      set_req(3, 1'b0, 4'h0, 30'h3FFFFC10, 32'h0, 8'h61); go();
      drain();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/tex_cache_responder.md
Name: tex_cache_responder

Overview:
- Read-mostly memory responder for the texture cache request bus: the responder end of the bus the texture unit drives as initiator.
- Has TCACHE-style ports (valid/ready request, valid/ready response with tag echo) and serves them from a shared word-addressed array.
- Each port has a fixed-latency read pipeline and an in-order response queue with credit-based admission.
- Used as the memory-side model in texture-unit testbenches and as a small on-chip texture scratch store.

Parameters:
NUM_REQS, 4, number of independent request/response ports
WORD_SIZE, 4, bytes per word
ADDR_WIDTH, 30, word address width
TAG_WIDTH, 8, request tag width, echoed unchanged on response
MEM_WORDS, 1024, array depth (power of 2); index = addr[log2(MEM_WORDS)-1:0]
LATENCY, 4, read latency in cycles from accept to response available (>=1)
QUEUE_DEPTH, 8, max outstanding reads per port (power of 2, >= LATENCY)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQS  per-port request valid
req_rw  in  NUM_REQS  1=write, 0=read
req_byteen  in  NUM_REQS*WORD_SIZE  write byte enables
req_addr  in  NUM_REQS*ADDR_WIDTH  word address
req_data  in  NUM_REQS*WORD_SIZE*8  write data
req_tag  in  NUM_REQS*TAG_WIDTH  request tag
req_ready  out  NUM_REQS  per-port request ready
rsp_valid  out  NUM_REQS  per-port response valid
rsp_data  out  NUM_REQS*WORD_SIZE*8  read data
rsp_tag  out  NUM_REQS*TAG_WIDTH  echoed tag
rsp_ready  in  NUM_REQS  per-port response ready

Behaviour:
- Reset (clk is the single clock; reset is asynchronous, active-low): clears pipelines, queues and credit counters. Outputs while in reset: req_ready=0, rsp_valid=0, rsp_data=0, rsp_tag=0. req_ready=1 from the first clk edge after reset deasserts. Array contents are NOT reset.
- Reset mid-operation: all in-flight reads are dropped and no response is ever issued for them.
- Fire conditions: request fire = req_valid&req_ready; response fire = rsp_valid&rsp_ready.
- Credits: per-port registered counter outstanding[p] (width log2(QUEUE_DEPTH)+1).
  - req_ready[p] = (outstanding[p] < QUEUE_DEPTH); registered, with no combinational path from req_valid or rsp_ready.
  - Read fire: +1. Response fire: -1. Both in the same cycle: unchanged.
- Writes:
  - Applied at the clk edge of the fire; byte-granular per req_byteen; no response, no credit consumed.
  - Writes to the same index from multiple ports in one cycle: the highest port index wins per byte.
- Reads:
  - Data is sampled from the array at the fire edge, read-before-write: a same-cycle write to the same index is not visible to that read, but is visible to reads fired 1+ cycles later.
  - Data and tag travel a LATENCY-stage valid pipeline, then enter a QUEUE_DEPTH-entry FIFO.
  - Read fired at edge t: rsp_valid rises at edge t+LATENCY if the queue ahead of it is empty. Back-to-back reads with rsp_ready=1 produce one response per cycle.
- Ordering: in-order within a port; ports are fully independent, so there is no cross-port ordering.
- Overflow: credits guarantee the FIFO never overflows. Push on a full FIFO is an assertion failure.
- rsp_valid/rsp_data/rsp_tag hold stable while rsp_valid=1 and rsp_ready=0.
- Out-of-range addr bits above the index are ignored (wrap-around aliasing).

Optional Feature:
TEX_RESPONDER_STALL_EN
- With it: each port has a 16-bit LFSR (seed 0xACE1 + port index, reset to seed) that masks req_ready low in cycles where lfsr[1:0]==0. The credit rule is still applied on top. Used to stress initiator backpressure.
- Without it: req_ready depends only on credits.

Test Plan:
- Write port0 addr 0x10 data 0xDEADBEEF byteen 0xF; 1 cycle later read port0 addr 0x10 tag 0x5A → rsp_valid exactly LATENCY=4 cycles after read fire, rsp_data=0xDEADBEEF, rsp_tag=0x5A.
- Same-cycle write 0x11111111 and read at addr 0x20 (old value 0) → read returns 0; a following read returns 0x11111111.
- rsp_ready=0, issue 9 reads on port1 → first 8 accepted, req_ready=0 after the 8th; raise rsp_ready → 8 responses in issue order with tags 0..7, req_ready returns 1 the cycle after the first response fires.
- Ports 0 and 3 write addr 0x30 with 0xAAAAAAAA / 0x55555555 in the same cycle → read returns 0x55555555. Byteen 0x1 write of 0xFF to 0x30 → 0x555555FF.
- Issue 3 reads, assert reset low for one cycle before responses → no rsp_valid ever for them; array still returns prior data after reset.
- Read addr MEM_WORDS+0x10 → returns contents of index 0x10.
